// File: rtl/br_issue_queue.sv
// Branch/jump reservation station: tracks operand readiness, snoops the CDB and
// issues the oldest ready micro-op into a registered slot. Optional BR_ISSUE_QUEUE_PERF_EN adds perf counters.

package br_issue_queue_pkg;
  localparam int unsigned RS_ROB_IDX_W = 4;

  typedef enum logic [1:0] {
    UOP_JAL  = 2'd0,
    UOP_JALR = 2'd1,
    UOP_BR   = 2'd2
  } br_uop_t;

  typedef struct packed {
    logic                    valid;
    br_uop_t                 uop;
    logic [2:0]              funct3;
    logic [31:0]             pc;
    logic [31:0]             imm;
    logic [RS_ROB_IDX_W-1:0] rob_idx;
    logic [31:0]             rs1_data;
    logic [31:0]             rs2_data;
  } reservation_station_t;
endpackage

module br_issue_queue
  import br_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROB_IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  reservation_station_t   dispatch_entry,
  input  logic                   dispatch_rs1_ready,
  input  logic                   dispatch_rs2_ready,
  input  logic [ROB_IDX_W-1:0]   dispatch_rs1_tag,
  input  logic [ROB_IDX_W-1:0]   dispatch_rs2_tag,
  input  logic                   cdb_valid,
  input  logic [ROB_IDX_W-1:0]   cdb_rob_idx,
  input  logic [31:0]            cdb_data,
  output reservation_station_t   next_execute,
`ifdef BR_ISSUE_QUEUE_PERF_EN
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            perf_issue_cnt,
  output logic [31:0]            perf_full_stall_cnt
`else
  output logic [$clog2(DEPTH):0] occupancy
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = IDX_W + 1;
  // Sequence numbers run modulo 2*DEPTH so a signed difference orders any two live entries.
  localparam int unsigned SEQ_W = IDX_W + 1;

  reservation_station_t ent_q [DEPTH];
  logic [DEPTH-1:0]     rs1_rdy_q;
  logic [DEPTH-1:0]     rs2_rdy_q;
  logic [ROB_IDX_W-1:0] rs1_tag_q [DEPTH];
  logic [ROB_IDX_W-1:0] rs2_tag_q [DEPTH];
  logic [SEQ_W-1:0]     seq_q [DEPTH];
  logic [SEQ_W-1:0]     seq_ctr_q;
  logic [OCC_W-1:0]     occ_q;
  reservation_station_t ne_q;

  logic [DEPTH-1:0]     rs1_hit;
  logic [DEPTH-1:0]     rs2_hit;
  logic [DEPTH-1:0]     elig;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 accept;
  logic                 disp_rs1_byp;
  logic                 disp_rs2_byp;
  reservation_station_t new_ent;
  reservation_station_t issue_ent;

  function automatic logic is_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] d;
    d = a - b;
    return d[SEQ_W-1];
  endfunction

  // CDB tag match per entry and same-cycle eligibility.
  always_comb begin
    rs1_hit = '0;
    rs2_hit = '0;
    elig    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs1_hit[i] = ent_q[i].valid && !rs1_rdy_q[i] && cdb_valid && (rs1_tag_q[i] == cdb_rob_idx);
      rs2_hit[i] = ent_q[i].valid && !rs2_rdy_q[i] && cdb_valid && (rs2_tag_q[i] == cdb_rob_idx);
      elig[i]    = ent_q[i].valid && (rs1_rdy_q[i] || rs1_hit[i]) && (rs2_rdy_q[i] || rs2_hit[i]);
    end
  end

  // Oldest eligible entry by dispatch sequence.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && (!sel_found || is_older(seq_q[i], seq_q[sel_idx]))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest-numbered free slot for the incoming micro-op.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign dispatch_ready = (occ_q < OCC_W'(DEPTH)) && !flush;
  assign accept         = dispatch_valid && dispatch_ready && free_found;
  assign disp_rs1_byp   = cdb_valid && !dispatch_rs1_ready && (dispatch_rs1_tag == cdb_rob_idx);
  assign disp_rs2_byp   = cdb_valid && !dispatch_rs2_ready && (dispatch_rs2_tag == cdb_rob_idx);

  // Incoming entry with CDB bypass, and issuing entry with same-cycle CDB merge.
  always_comb begin
    new_ent       = dispatch_entry;
    new_ent.valid = 1'b1;
    if (disp_rs1_byp) new_ent.rs1_data = cdb_data;
    if (disp_rs2_byp) new_ent.rs2_data = cdb_data;
    issue_ent       = ent_q[sel_idx];
    issue_ent.valid = 1'b1;
    if (rs1_hit[sel_idx]) issue_ent.rs1_data = cdb_data;
    if (rs2_hit[sel_idx]) issue_ent.rs2_data = cdb_data;
  end

  // Entry storage: wakeup, issue invalidation and allocation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]     <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        seq_q[i]     <= '0;
      end
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      seq_ctr_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rs1_hit[i]) begin
          ent_q[i].rs1_data <= cdb_data;
          rs1_rdy_q[i]      <= 1'b1;
        end
        if (rs2_hit[i]) begin
          ent_q[i].rs2_data <= cdb_data;
          rs2_rdy_q[i]      <= 1'b1;
        end
        if (sel_found && (sel_idx == IDX_W'(i))) begin
          ent_q[i].valid <= 1'b0;
        end
        if (accept && (free_idx == IDX_W'(i))) begin
          ent_q[i]     <= new_ent;
          rs1_rdy_q[i] <= dispatch_rs1_ready || disp_rs1_byp;
          rs2_rdy_q[i] <= dispatch_rs2_ready || disp_rs2_byp;
          rs1_tag_q[i] <= dispatch_rs1_tag;
          rs2_tag_q[i] <= dispatch_rs2_tag;
          seq_q[i]     <= seq_ctr_q;
        end
      end
      if (accept) seq_ctr_q <= seq_ctr_q + SEQ_W'(1);
    end
  end

  // Occupancy and registered issue slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
      ne_q  <= '0;
    end else if (flush) begin
      occ_q      <= '0;
      ne_q.valid <= 1'b0;
    end else begin
      occ_q <= occ_q + OCC_W'(accept) - OCC_W'(sel_found);
      if (sel_found) ne_q <= issue_ent;
      else           ne_q.valid <= 1'b0;
    end
  end

  assign occupancy    = occ_q;
  assign next_execute = ne_q;

`ifdef BR_ISSUE_QUEUE_PERF_EN
  logic [31:0] perf_issue_q;
  logic [31:0] perf_stall_q;

  // Saturating issue and full-stall counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else if (flush) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (sel_found && (perf_issue_q != 32'hFFFF_FFFF)) perf_issue_q <= perf_issue_q + 32'd1;
      if (dispatch_valid && !dispatch_ready && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue_cnt      = perf_issue_q;
  assign perf_full_stall_cnt = perf_stall_q;
`endif

endmodule
